seq_alu: RTL and testbench
==========================

SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port in_valid  input  1  operand/opcode presented.
REQ-005 SHALL have port in_ready  output  1  block accepts operation this cycle.
REQ-006 SHALL have port a  input  WIDTH  operand A.
REQ-007 SHALL have port b  input  WIDTH  operand B.
REQ-008 SHALL have port opcode  input  3  operation select.
REQ-009 SHALL have port out_valid  output  1  result/flags valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port result  output  WIDTH  registered result.
REQ-012 SHALL have port flags  output  4  registered {ovf, neg, carry, zero}, bit 0 = zero.
REQ-013 SHALL have port err  output  1  registered; opcode unsupported in this build.

Function
REQ-014 SHALL decode opcode: 000 ADD, 001 SUB (a-b), 010 AND, 011 OR, 100 XOR, 101 NOR, 110 SHL (a << b[$clog2(WIDTH)-1:0]), 111 MUL (see REQ-030).
REQ-015 SHALL accept an operation on a rising edge where in_valid && in_ready (transfer); operands SHALL be captured at transfer and later input changes ignored.
REQ-016 SHALL implement FSM states IDLE, BUSY, HOLD; reset state IDLE.
REQ-017 IDLE: in_ready=1, out_valid=0; transfer of single-cycle op -> HOLD; transfer of MUL (enabled) -> BUSY.
REQ-018 BUSY: in_ready=0, out_valid=0; after the final multiply iteration -> HOLD.
REQ-019 HOLD: out_valid=1; in_ready=out_ready; out_ready=1 with in_valid=1 SHALL complete output and accept next op in the same cycle (-> HOLD or BUSY); out_ready=1 without in_valid -> IDLE; out_ready=0 -> stay HOLD with result, flags, err held stable.
REQ-020 Single-cycle op latency SHALL be 1: transfer at edge N -> out_valid high after edge N; sustained throughput 1 op/cycle with out_ready=1.
REQ-021 result SHALL be the low WIDTH bits of the operation (mod 2^WIDTH wrap-around).
REQ-022 zero SHALL be 1 iff result == 0.
REQ-023 neg SHALL equal result[WIDTH-1].
REQ-024 carry SHALL be: ADD carry-out; SUB borrow (a < b unsigned); SHL OR of bits shifted out; MUL 1 iff high WIDTH product bits nonzero; otherwise 0.
REQ-025 ovf SHALL be two's-complement signed overflow for ADD/SUB, 0 for all others.
REQ-026 SHL with shift amount 0 SHALL return a unchanged with carry=0.

Reset
REQ-027 rst_n low SHALL immediately (asynchronously) force state IDLE, in_ready=1, out_valid=0, result=0, flags=0, err=0, multiply registers cleared.
REQ-028 Reset asserted during BUSY or HOLD SHALL discard the pending operation; no result is produced after release.
REQ-029 Deassertion SHALL be used as-is; first transfer possible on the first rising edge with rst_n high.

Configuration
REQ-030 Macro SEQ_ALU_MUL_EN defined: opcode 111 SHALL be unsigned shift-add multiply, one partial product per cycle, WIDTH cycles in BUSY, out_valid high exactly WIDTH cycles after transfer edge, err=0.
REQ-031 Macro SEQ_ALU_MUL_EN undefined: opcode 111 SHALL complete as a single-cycle op with result=0, flags={0,0,0,1}, err=1; no BUSY state or multiply datapath is synthesised.

Verification
REQ-032 WIDTH=8, ADD a=8'hFF b=8'h01, out_ready=1 -> next cycle result=8'h00, flags=4'b0011, err=0.
REQ-033 WIDTH=8, SUB a=8'h80 b=8'h01 -> result=8'h7F, ovf=1, neg=0, carry=0, zero=0; SUB a=3 b=5 -> result=8'hFE, carry=1, neg=1.
REQ-034 WIDTH=8, back-to-back AND/OR/XOR/NOR on a=8'h08 b=8'h04 with out_ready=1 -> results 00,0C,0C,F3 on four consecutive cycles, in_ready never low.
REQ-035 out_ready=0 for 5 cycles after SHL a=8'hC1 b=1 -> result=8'h82, carry=1 held stable, in_ready=0 throughout; release -> one transfer only.
REQ-036 SEQ_ALU_MUL_EN, WIDTH=8, MUL a=20 b=15 -> out_valid 8 cycles later, result=8'h2C, carry=1; rst_n pulsed low in cycle 4 of BUSY -> no result, outputs zero.
REQ-037 SEQ_ALU_MUL_EN undefined, opcode 111 -> next cycle result=0, zero=1, err=1.

Source files
------------

// File: rtl/seq_alu.sv
// seq_alu: valid/ready ALU with registered result, flags and err.
// Define SEQ_ALU_MUL_EN to build the iterative shift-add multiply for opcode 111.
module seq_alu #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             err
);
    localparam int SW = $clog2(WIDTH);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

`ifdef SEQ_ALU_MUL_EN
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        HOLD = 2'b10
    } state_t;
`else
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             err_q, err_d;
    logic             xfer;

    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [3*WIDTH-1:0] shl_ext;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_carry;
    logic               alu_ovf;
    logic               alu_err;
    logic [3:0]         alu_flags;

    assign out_valid = (state_q == HOLD);
    assign in_ready  = (state_q == IDLE) || ((state_q == HOLD) && out_ready);
    assign xfer      = in_valid && in_ready;

    assign result = result_q;
    assign flags  = flags_q;
    assign err    = err_q;

    // Single-cycle datapath, evaluated on the live inputs and captured only at transfer.
    always_comb begin
        sum_ext   = {1'b0, a} + {1'b0, b};
        diff_ext  = {1'b0, a} - {1'b0, b};
        // Wide enough that no shifted-out bit is lost, even for non-power-of-two WIDTH.
        shl_ext   = {{(2*WIDTH){1'b0}}, a} << b[SW-1:0];
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        alu_err   = 1'b0;
        case (opcode)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
                alu_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: alu_res = a & b;
            OP_OR:  alu_res = a | b;
            OP_XOR: alu_res = a ^ b;
            OP_NOR: alu_res = ~(a | b);
            OP_SHL: begin
                alu_res   = shl_ext[WIDTH-1:0];
                alu_carry = |shl_ext[3*WIDTH-1:WIDTH];
            end
            OP_MUL: begin
`ifndef SEQ_ALU_MUL_EN
                alu_err = 1'b1;
`endif
            end
        endcase
        alu_flags = {alu_ovf, alu_res[WIDTH-1], alu_carry, (alu_res == '0)};
    end

`ifdef SEQ_ALU_MUL_EN
    localparam int             CW       = SW + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_mul;

    assign is_mul   = (opcode == OP_MUL);
    assign acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        err_d    = err_q;
`ifdef SEQ_ALU_MUL_EN
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
`endif
        case (state_q)
            IDLE: begin
            end
            HOLD: begin
                if (out_ready && !in_valid) begin
                    state_d = IDLE;
                end
            end
`ifdef SEQ_ALU_MUL_EN
            BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d  = HOLD;
                    result_d = acc_step[WIDTH-1:0];
                    flags_d  = {1'b0, acc_step[WIDTH-1], |acc_step[2*WIDTH-1:WIDTH],
                                (acc_step[WIDTH-1:0] == '0)};
                    err_d    = 1'b0;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A transfer in HOLD overrides the HOLD->IDLE decision above.
        if (xfer) begin
`ifdef SEQ_ALU_MUL_EN
            if (is_mul) begin
                state_d  = BUSY;
                mcand_d  = {{WIDTH{1'b0}}, a};
                mplier_d = b;
                acc_d    = '0;
                cnt_d    = '0;
            end else
`endif
            begin
                state_d  = HOLD;
                result_d = alu_res;
                flags_d  = alu_flags;
                err_d    = alu_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            err_q    <= err_d;
        end
    end

`ifdef SEQ_ALU_MUL_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu (WIDTH=8) against an arithmetic model.
module tb_seq_alu;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    // Reference: integer arithmetic straight from the operation definitions.
    function automatic void ref_model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                                      output logic [7:0] r, output logic [3:0] f, output logic e);
        int ua, ub, sa, sb, s, full;
        logic c, o;
        ua = int'(x);
        ub = int'(y);
        sa = int'($signed(x));
        sb = int'($signed(y));
        full = 0;
        c = 1'b0;
        o = 1'b0;
        e = 1'b0;
        case (op)
            3'd0: begin full = ua + ub; c = (full > 255); s = sa + sb; o = (s > 127) || (s < -128); end
            3'd1: begin full = ua - ub; c = (ua < ub);    s = sa - sb; o = (s > 127) || (s < -128); end
            3'd2: full = ua & ub;
            3'd3: full = ua | ub;
            3'd4: full = ua ^ ub;
            3'd5: full = 255 - (ua | ub);
            3'd6: begin full = ua * (1 << (ub % 8)); c = (full > 255); end
            default: begin
`ifdef SEQ_ALU_MUL_EN
                full = ua * ub;
                c = (full > 255);
`else
                full = 0;
                e = 1'b1;
`endif
            end
        endcase
        r = full[7:0];
        f = {o, r[7], c, (r == 8'h00)};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = 8'h00; b = 8'h00; opcode = 3'd0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({in_ready, out_valid, result, flags, err} !== {1'b1, 1'b0, 8'h00, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got rdy=%b v=%b r=%h f=%b e=%b, want rdy=1 v=0 r=00 f=0000 e=0",
                     in_ready, out_valid, result, flags, err);
        end
        rst_n = 1'b1;
        $display("reset released");
    endtask

    task automatic test_add_sub();
        out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd0; a = 8'hFF; b = 8'h01;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'h00, 4'b0011, 1'b0}) begin
            n_err++;
            $display("FAIL add_wrap: got v=%b r=%h f=%b e=%b, want v=1 r=00 f=0011 e=0", out_valid, result, flags, err);
        end
        $display("ADD FF+01 -> r=%h f=%b", result, flags);
        opcode = 3'd1; a = 8'h80; b = 8'h01;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'h7F, 4'b1000, 1'b0}) begin
            n_err++;
            $display("FAIL sub_ovf: got v=%b r=%h f=%b e=%b, want v=1 r=7f f=1000 e=0", out_valid, result, flags, err);
        end
        $display("SUB 80-01 -> r=%h f=%b", result, flags);
        a = 8'h03; b = 8'h05;
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'hFE, 4'b0110, 1'b0}) begin
            n_err++;
            $display("FAIL sub_borrow: got v=%b r=%h f=%b e=%b, want v=1 r=fe f=0110 e=0", out_valid, result, flags, err);
        end
        $display("SUB 03-05 -> r=%h f=%b", result, flags);
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL idle_return: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_r [4];
        exp_r[0] = 8'h00; exp_r[1] = 8'h0C; exp_r[2] = 8'h0C; exp_r[3] = 8'hF3;
        out_ready = 1'b1; a = 8'h08; b = 8'h04;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                opcode = 3'(i + 2);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_ready[%0d]: got rdy=%b, want rdy=1", i, in_ready);
            end
            @(negedge clk);
            if (i < 4) begin
                n_cmp++;
                if ({out_valid, result} !== {1'b1, exp_r[i]}) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got v=%b r=%h, want v=1 r=%h", i, out_valid, result, exp_r[i]);
                end
                $display("b2b op=%0d -> r=%h", i + 2, result);
            end
        end
    endtask

    task automatic test_hold_stall();
        in_valid = 1'b1; opcode = 3'd6; a = 8'hC1; b = 8'h01; out_ready = 1'b0;
        @(negedge clk);
        opcode = 3'd0; a = 8'h01; b = 8'h01;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_cmp++;
            if ({out_valid, in_ready, result, flags, err} !== {1'b1, 1'b0, 8'h82, 4'b0110, 1'b0}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got v=%b rdy=%b r=%h f=%b e=%b, want v=1 rdy=0 r=82 f=0110 e=0",
                         i, out_valid, in_ready, result, flags, err);
            end
            $display("stall cycle %0d r=%h f=%b", i, result, flags);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result, flags} !== {1'b1, 8'h02, 4'b0000}) begin
            n_err++;
            $display("FAIL stall_release: got v=%b r=%h f=%b, want v=1 r=02 f=0000", out_valid, result, flags);
        end
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL stall_single_xfer: got v=%b, want v=0", out_valid);
        end
    endtask

    task automatic test_mul();
`ifdef SEQ_ALU_MUL_EN
        out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd7; a = 8'd20; b = 8'd15;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                in_valid = 1'b0; a = 8'hAA; b = 8'hAA;
            end
            #1;
            n_cmp++;
            if ({out_valid, in_ready} !== 2'b00) begin
                n_err++;
                $display("FAIL mul_busy[%0d]: got v=%b rdy=%b, want v=0 rdy=0", k, out_valid, in_ready);
            end
        end
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'h2C, 4'b0010, 1'b0}) begin
            n_err++;
            $display("FAIL mul_result: got v=%b r=%h f=%b e=%b, want v=1 r=2c f=0010 e=0", out_valid, result, flags, err);
        end
        $display("MUL 20*15 -> r=%h f=%b", result, flags);
        @(negedge clk);
        in_valid = 1'b1; opcode = 3'd7; a = 8'd20; b = 8'd15;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result, flags, err} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL mul_reset: got v=%b rdy=%b r=%h f=%b e=%b, want v=0 rdy=1 r=00 f=0000 e=0",
                     out_valid, in_ready, result, flags, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({out_valid, result} !== {1'b0, 8'h00}) begin
                n_err++;
                $display("FAIL mul_discard[%0d]: got v=%b r=%h, want v=0 r=00", k, out_valid, result);
            end
        end
`else
        out_ready = 1'b1; in_valid = 1'b1; opcode = 3'd7; a = 8'($urandom); b = 8'($urandom);
        @(negedge clk);
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'h00, 4'b0001, 1'b1}) begin
            n_err++;
            $display("FAIL mul_disabled: got v=%b r=%h f=%b e=%b, want v=1 r=00 f=0001 e=1", out_valid, result, flags, err);
        end
        $display("opcode 111 -> r=%h f=%b e=%b", result, flags, err);
        opcode = 3'd0; a = 8'd2; b = 8'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result, flags, err} !== {1'b1, 8'h05, 4'b0000, 1'b0}) begin
            n_err++;
            $display("FAIL err_clear: got v=%b r=%h f=%b e=%b, want v=1 r=05 f=0000 e=0", out_valid, result, flags, err);
        end
        @(negedge clk);
`endif
    endtask

    task automatic test_reset_hold();
        in_valid = 1'b1; opcode = 3'd4; a = 8'h5A; b = 8'h0F; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, result} !== {1'b1, 8'h55}) begin
            n_err++;
            $display("FAIL xor_hold: got v=%b r=%h, want v=1 r=55", out_valid, result);
        end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({out_valid, in_ready, result, flags, err} !== {1'b0, 1'b1, 8'h00, 4'h0, 1'b0}) begin
            n_err++;
            $display("FAIL hold_reset: got v=%b rdy=%b r=%h f=%b e=%b, want v=0 rdy=1 r=00 f=0000 e=0",
                     out_valid, in_ready, result, flags, err);
        end
        @(negedge clk);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL hold_discard[%0d]: got v=%b, want v=0", k, out_valid);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] qr[$];
        logic [3:0] qf[$];
        logic       qe[$];
        logic [7:0] er;
        logic [3:0] ef;
        logic       ee;
        for (int cyc = 0; cyc < 420; cyc++) begin
            @(negedge clk);
            if (cyc < 380) begin
                in_valid  = ($urandom_range(0, 9) < 7);
                out_ready = ($urandom_range(0, 9) < 7);
                opcode    = 3'($urandom_range(0, 7));
                a         = 8'($urandom);
                b         = 8'($urandom);
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            #1;
            if (out_valid) begin
                n_cmp++;
                if (qr.size() == 0) begin
                    n_err++;
                    $display("FAIL rand_spurious[%0d]: got v=1 r=%h, want no pending result", cyc, result);
                end else begin
                    if ({result, flags, err} !== {qr[0], qf[0], qe[0]}) begin
                        n_err++;
                        $display("FAIL rand_result[%0d]: got r=%h f=%b e=%b, want r=%h f=%b e=%b",
                                 cyc, result, flags, err, qr[0], qf[0], qe[0]);
                    end
                    if (out_ready) begin
                        $display("rand out cyc=%0d r=%h f=%b e=%b", cyc, result, flags, err);
                        void'(qr.pop_front());
                        void'(qf.pop_front());
                        void'(qe.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                ref_model(opcode, a, b, er, ef, ee);
                qr.push_back(er);
                qf.push_back(ef);
                qe.push_back(ee);
            end
        end
        n_cmp++;
        if (qr.size() != 0) begin
            n_err++;
            $display("FAIL rand_drain: got %0d results still pending, want 0", qr.size());
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_add_sub();
        test_back_to_back();
        test_hold_stall();
        test_mul();
        test_reset_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
